// File: rtl/probing_hash_table.sv
// Open-addressing hash table with linear probing and tombstone deletes.
// A request is accepted in IDLE; PROBE examines one slot per cycle and
// issues a registered one-cycle response pulse when the command decides.
module probing_hash_table #(
    parameter int KEY_W  = 8,
    parameter int VAL_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_hash,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [VAL_W-1:0]  req_val,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [VAL_W-1:0]  rsp_val,
    output logic [ADDR_W:0]   rsp_probes,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_PROBE = 1'b1;

    localparam logic [1:0] CMD_LOOKUP = 2'd0;
    localparam logic [1:0] CMD_INSERT = 2'd1;
    localparam logic [1:0] CMD_DELETE = 2'd2;
    localparam logic [1:0] CMD_CLEAR  = 2'd3;

    localparam logic [1:0] SLOT_EMPTY = 2'd0;
    localparam logic [1:0] SLOT_FULL  = 2'd1;
    localparam logic [1:0] SLOT_TOMB  = 2'd2;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_FULL     = 2'd1;
    localparam logic [1:0] ST_NOTFOUND = 2'd2;
    localparam logic [1:0] ST_UPDATED  = 2'd3;

    logic [1:0]       slot_st  [DEPTH];
    logic [KEY_W-1:0] key_mem  [DEPTH];
    logic [VAL_W-1:0] val_mem  [DEPTH];

    logic [0:0]        state;
    logic [1:0]        cmd_q;
    logic [KEY_W-1:0]  key_q;
    logic [VAL_W-1:0]  val_q;
    logic [ADDR_W-1:0] cursor;
    logic [ADDR_W-1:0] n;
    logic              tomb_seen;
    logic [ADDR_W-1:0] tomb_idx;

    logic [1:0]        cur_st;
    logic              hit;
    logic              decide;
    logic              clr_all;
    logic              set_tomb;
    logic              overwrite;
    logic              wr_new;
    logic [ADDR_W-1:0] wr_idx;
    logic              cnt_inc;
    logic              cnt_dec;
    logic              mark_tomb;
    logic [1:0]        status_d;
    logic [VAL_W-1:0]  val_d;
    logic              accept;
    logic              fire;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign fire      = (state == S_PROBE) && decide;
    assign cur_st    = slot_st[cursor];
    assign hit       = (cur_st == SLOT_FULL) && (key_mem[cursor] == key_q);

    // Decision rules for the slot under the cursor, in priority order
    always_comb begin
        decide    = 1'b0;
        clr_all   = 1'b0;
        set_tomb  = 1'b0;
        overwrite = 1'b0;
        wr_new    = 1'b0;
        wr_idx    = cursor;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        mark_tomb = 1'b0;
        status_d  = ST_OK;
        val_d     = '0;
        if (cmd_q == CMD_CLEAR) begin
            decide  = 1'b1;
            clr_all = 1'b1;
        end else if (hit) begin
            decide = 1'b1;
            val_d  = val_mem[cursor];
            if (cmd_q == CMD_DELETE) begin
                set_tomb = 1'b1;
                cnt_dec  = 1'b1;
            end else if (cmd_q == CMD_INSERT) begin
                overwrite = 1'b1;
                status_d  = ST_UPDATED;
            end
        end else if (cur_st == SLOT_EMPTY) begin
            decide = 1'b1;
            if (cmd_q == CMD_INSERT) begin
                wr_new  = 1'b1;
                wr_idx  = tomb_seen ? tomb_idx : cursor;
                cnt_inc = 1'b1;
            end else begin
                status_d = ST_NOTFOUND;
            end
        end else if (n == '1) begin
            decide = 1'b1;
            if (cmd_q == CMD_INSERT) begin
                // The last slot itself may be the first tombstone of the chain
                if (tomb_seen) begin
                    wr_new  = 1'b1;
                    wr_idx  = tomb_idx;
                    cnt_inc = 1'b1;
                end else if (cur_st == SLOT_TOMB) begin
                    wr_new  = 1'b1;
                    wr_idx  = cursor;
                    cnt_inc = 1'b1;
                end else begin
                    status_d = ST_FULL;
                end
            end else begin
                status_d = ST_NOTFOUND;
            end
        end else begin
            mark_tomb = (cur_st == SLOT_TOMB) && !tomb_seen;
        end
    end

    // Slot state array: cleared on reset and on CLEAR, updated at the decision edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) slot_st[i] <= SLOT_EMPTY;
        end else if (fire) begin
            if (clr_all) begin
                for (int unsigned i = 0; i < DEPTH; i++) slot_st[i] <= SLOT_EMPTY;
            end else if (set_tomb) begin
                slot_st[cursor] <= SLOT_TOMB;
            end else if (wr_new) begin
                slot_st[wr_idx] <= SLOT_FULL;
            end
        end
    end

    // Key/value storage is unreset; slot state decides whether it is meaningful
    always_ff @(posedge clk) begin
        if (fire && wr_new) begin
            key_mem[wr_idx] <= key_q;
            val_mem[wr_idx] <= val_q;
        end else if (fire && overwrite) begin
            val_mem[cursor] <= val_q;
        end
    end

    // Control FSM, probe cursor, response registers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_q      <= CMD_LOOKUP;
            key_q      <= '0;
            val_q      <= '0;
            cursor     <= '0;
            n          <= '0;
            tomb_seen  <= 1'b0;
            tomb_idx   <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_val    <= '0;
            rsp_probes <= '0;
            count      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    cmd_q     <= req_cmd;
                    key_q     <= req_key;
                    val_q     <= req_val;
                    cursor    <= req_hash;
                    n         <= '0;
                    tomb_seen <= 1'b0;
                    state     <= S_PROBE;
                end
            end else if (decide) begin
                rsp_valid  <= 1'b1;
                rsp_status <= status_d;
                rsp_val    <= val_d;
                rsp_probes <= {1'b0, n} + (ADDR_W+1)'(1);
                state      <= S_IDLE;
                if (clr_all) begin
                    count <= '0;
                end else if (cnt_inc && (count < DEPTH_C)) begin
                    count <= count + (ADDR_W+1)'(1);
                end else if (cnt_dec && (count != '0)) begin
                    count <= count - (ADDR_W+1)'(1);
                end
            end else begin
                if (mark_tomb) begin
                    tomb_seen <= 1'b1;
                    tomb_idx  <= cursor;
                end
                cursor <= cursor + ADDR_W'(1);
                n      <= n + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_probing_hash_table.sv
// Bench for probing_hash_table: directed vector table, randomized traffic
// against a slot-array reference model, and a mid-operation reset sequence.
module tb_probing_hash_table;

    localparam int KW    = 8;
    localparam int VW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    localparam int C_LOOKUP = 0, C_INSERT = 1, C_DELETE = 2, C_CLEAR = 3;
    localparam int R_OK = 0, R_FULL = 1, R_NOTFOUND = 2, R_UPDATED = 3;
    localparam int M_EMPTY = 0, M_FULL = 1, M_TOMB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_cmd;
    logic [AW-1:0] req_hash;
    logic [KW-1:0] req_key;
    logic [VW-1:0] req_val;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [VW-1:0] rsp_val;
    logic [AW:0]   rsp_probes;
    logic [AW:0]   count;

    int errors = 0;
    int checks = 0;

    probing_hash_table #(.KEY_W(KW), .VAL_W(VW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_hash   (req_hash),
        .req_key    (req_key),
        .req_val    (req_val),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rsp_val    (rsp_val),
        .rsp_probes (rsp_probes),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Reference model: plain per-slot arrays
    int m_st  [DEPTH];
    int m_key [DEPTH];
    int m_val [DEPTH];
    int m_cnt;

    typedef struct {
        int cmd; int hash; int key; int val;
        int est; int eval; int epr; int ecnt;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_st[i] = M_EMPTY;
        m_cnt = 0;
    endtask

    // Walk the chain from hash; first matching key wins, an EMPTY ends it
    task automatic model_op(input int c, input int h, input int k, input int v,
                            output int st, output int rv, output int pr);
        int ft;
        st = R_NOTFOUND; rv = 0; pr = DEPTH; ft = -1;
        if (c == C_CLEAR) begin
            model_reset();
            st = R_OK; pr = 1;
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            int idx;
            idx = (h + i) % DEPTH;
            if (m_st[idx] == M_FULL && m_key[idx] == k) begin
                pr = i + 1; rv = m_val[idx]; st = R_OK;
                if (c == C_DELETE) begin m_st[idx] = M_TOMB; m_cnt--; end
                if (c == C_INSERT) begin m_val[idx] = v; st = R_UPDATED; end
                return;
            end
            if (m_st[idx] == M_EMPTY) begin
                pr = i + 1;
                if (c == C_INSERT) begin
                    if (ft < 0) ft = idx;
                    m_st[ft] = M_FULL; m_key[ft] = k; m_val[ft] = v; m_cnt++;
                    st = R_OK;
                end
                return;
            end
            if (m_st[idx] == M_TOMB && ft < 0) ft = idx;
        end
        if (c == C_INSERT) begin
            if (ft >= 0) begin
                m_st[ft] = M_FULL; m_key[ft] = k; m_val[ft] = v; m_cnt++;
                st = R_OK;
            end else begin
                st = R_FULL;
            end
        end
    endtask

    // Issue one request starting at a negedge with the DUT idle; returns at
    // the negedge where rsp_valid is seen (or after the cycle budget)
    task automatic do_req(input int c, input int h, input int k, input int v,
                          output int st, output int rv, output int pr,
                          output int lat, output bit ok);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_cmd = 2'(c); req_hash = AW'(h); req_key = KW'(k); req_val = VW'(v);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b0; lat = 0; st = 0; rv = 0; pr = 0;
        for (int i = 1; i <= DEPTH + 4; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1; lat = i - 1;
                st = int'(rsp_status); rv = int'(rsp_val); pr = int'(rsp_probes);
                break;
            end
        end
    endtask

    task automatic run_exp(input string tag, input int c, input int h, input int k, input int v,
                           input int est, input int eval, input int epr, input int ecnt);
        int st, rv, pr, lat;
        bit ok;
        do_req(c, h, k, v, st, rv, pr, lat, ok);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no rsp_valid expected rsp_valid within %0d cycles", tag, DEPTH + 4);
            return;
        end
        chk({tag, "_status"}, st, est);
        chk({tag, "_val"}, rv, eval);
        chk({tag, "_probes"}, pr, epr);
        chk({tag, "_latency"}, lat, epr);
        chk({tag, "_count"}, {27'd0, count}, ecnt);
        chk({tag, "_ready_at_rsp"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_model(input string tag, input int c, input int h, input int k, input int v);
        int est, ev, epr;
        model_op(c, h, k, v, est, ev, epr);
        run_exp(tag, c, h, k, v, est, ev, epr, m_cnt);
    endtask

    task automatic add(input int c, input int h, input int k, input int v,
                       input int est, input int eval, input int epr, input int ecnt);
        vec_t t;
        t.cmd = c; t.hash = h; t.key = k; t.val = v;
        t.est = est; t.eval = eval; t.epr = epr; t.ecnt = ecnt;
        vq.push_back(t);
    endtask

    initial begin
        int pulses;
        int d0, d1, d2;
        rst_n = 1'b0; req_valid = 1'b0;
        req_cmd = '0; req_hash = '0; req_key = '0; req_val = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_status", {30'd0, rsp_status}, 32'd0);
        chk("rst_val", {24'd0, rsp_val}, 32'd0);
        chk("rst_probes", {27'd0, rsp_probes}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // Directed vectors: chain building, tombstone reuse, update, full table, wrap
        add(C_LOOKUP, 3, 'h11, 0,    R_NOTFOUND, 0,    1, 0);
        add(C_INSERT, 3, 'h11, 'hAA, R_OK,       0,    1, 1);
        add(C_INSERT, 3, 'h22, 'hBB, R_OK,       0,    2, 2);
        add(C_LOOKUP, 3, 'h22, 0,    R_OK,       'hBB, 2, 2);
        add(C_DELETE, 3, 'h11, 0,    R_OK,       'hAA, 1, 1);
        add(C_LOOKUP, 3, 'h22, 0,    R_OK,       'hBB, 2, 1);
        add(C_INSERT, 3, 'h33, 'h01, R_OK,       0,    3, 2);
        add(C_LOOKUP, 3, 'h33, 0,    R_OK,       'h01, 1, 2);
        add(C_INSERT, 3, 'h22, 'hCC, R_UPDATED,  'hBB, 2, 2);
        add(C_LOOKUP, 3, 'h22, 0,    R_OK,       'hCC, 2, 2);
        add(C_CLEAR,  0, 0,    0,    R_OK,       0,    1, 0);
        for (int i = 0; i < DEPTH; i++)
            add(C_INSERT, 0, 'h40 + i, i + 1, R_OK, 0, i + 1, i + 1);
        add(C_INSERT, 0, 'h7F, 'h55, R_FULL,     0,    DEPTH, DEPTH);
        add(C_LOOKUP, 0, 'h7E, 0,    R_NOTFOUND, 0,    DEPTH, DEPTH);
        add(C_LOOKUP, 5, 'h4F, 0,    R_OK,       16,   11, DEPTH);
        add(C_CLEAR,  9, 0,    0,    R_OK,       0,    1, 0);
        add(C_INSERT, 15, 'h01, 'h10, R_OK,      0,    1, 1);
        add(C_INSERT, 15, 'h02, 'h20, R_OK,      0,    2, 2);
        add(C_LOOKUP, 15, 'h02, 0,    R_OK,      'h20, 2, 2);
        add(C_DELETE, 15, 'h05, 0,    R_NOTFOUND, 0,   3, 2);

        foreach (vq[i]) begin
            int s, r, p;
            model_op(vq[i].cmd, vq[i].hash, vq[i].key, vq[i].val, s, r, p);
            run_exp($sformatf("vec%0d", i), vq[i].cmd, vq[i].hash, vq[i].key, vq[i].val,
                    vq[i].est, vq[i].eval, vq[i].epr, vq[i].ecnt);
        end

        // Randomized traffic; small key space forces full tables and tombstone chains
        for (int i = 0; i < 400; i++) begin
            int r, c;
            r = int'($urandom_range(0, 99));
            c = (r < 42) ? C_INSERT : (r < 72) ? C_LOOKUP : (r < 98) ? C_DELETE : C_CLEAR;
            run_model($sformatf("rnd%0d", i), c, int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(0, 23)), int'($urandom_range(0, 255)));
        end

        // Reset in the middle of a 10-probe LOOKUP
        run_model("pre_clear", C_CLEAR, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            run_model($sformatf("pre_ins%0d", i), C_INSERT, 0, 'h80 + i, i);
        req_cmd = 2'(C_LOOKUP); req_hash = '0; req_key = 8'hFE; req_val = '0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rstmid_ready_in_reset", {31'd0, req_ready}, 32'd1);
        #2 rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rstmid_no_pulse", pulses, 0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_count", {27'd0, count}, 32'd0);
        model_reset();
        model_op(C_LOOKUP, 0, 'h80, 0, d0, d1, d2);
        run_exp("post_rst_lk0", C_LOOKUP, 0, 'h80, 0, R_NOTFOUND, 0, 1, 0);
        run_model("post_rst_lk1", C_LOOKUP, 1, 'h81, 0);
        run_model("post_rst_ins", C_INSERT, 2, 'h82, 'h77);
        run_model("post_rst_lk2", C_LOOKUP, 2, 'h82, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected completion within 2000000 time units");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/probing_hash_table.md
Name: probing_hash_table

Overview:
Parametrised open-addressing hash table using linear probing, with a valid/ready request port and a registered one-cycle response pulse. The caller supplies the precomputed hash. Deletes leave tombstones, so probe chains stay intact after a delete. Inserts update an existing key in place and otherwise reuse the first tombstone on the chain. The block provides an occupancy count and a single-command CLEAR; it is the next-generation key/value store for the hash-table datapath.

Parameters:
KEY_W, 8, key width in bits
VAL_W, 8, value width in bits
ADDR_W, 4, log2 of table depth (DEPTH = 2**ADDR_W slots)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request; high iff FSM is in IDLE
req_cmd  input  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=CLEAR
req_hash  input  ADDR_W  start slot for the probe
req_key  input  KEY_W  key
req_val  input  VAL_W  value (used by INSERT only)
rsp_valid  output  1  one-cycle response pulse
rsp_status  output  2  0=OK, 1=FULL, 2=NOTFOUND, 3=UPDATED
rsp_val  output  VAL_W  returned value
rsp_probes  output  ADDR_W+1  number of slots examined by the command
count  output  ADDR_W+1  number of FULL slots

Behaviour:
- Storage: DEPTH slots, each holding state {EMPTY, FULL, TOMB} plus key and value.
- Reset: all slot states go to EMPTY. Key/value storage is not reset and is not observable.
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_status=0, rsp_val=0, rsp_probes=0, count=0.
- Reset asserted mid-operation aborts the operation immediately; no response is issued.
- Handshake: a request is accepted on an edge where req_valid && req_ready. At that edge req_cmd, req_hash, req_key and req_val are latched, then cursor=req_hash, n=0, tomb_seen=0, and FSM goes to PROBE. Inputs are ignored at all other times.
- rsp_valid has no backpressure.
- PROBE state: examines slot[cursor] once per cycle.
- Decision rules, evaluated in priority order:
  1. CLEAR: every slot state set to EMPTY; count=0; status OK; probes 1.
  2. Slot FULL and key matches:
     - LOOKUP: status OK, rsp_val = stored value.
     - DELETE: slot set to TOMB, count-1, status OK, rsp_val = deleted value.
     - INSERT: value overwritten, status UPDATED, rsp_val = old value, count unchanged.
  3. Slot EMPTY:
     - LOOKUP/DELETE: status NOTFOUND.
     - INSERT: write {key, val} to the first tombstone if tomb_seen, else to this slot; slot becomes FULL; count+1; status OK.
  4. Slot is TOMB or a FULL mismatch, and n==DEPTH-1 (last slot of the loop):
     - LOOKUP/DELETE: NOTFOUND.
     - INSERT: if tomb_seen or this slot is TOMB, write to the first tombstone, count+1, OK; else FULL.
  5. Otherwise: if slot is TOMB and !tomb_seen, record tomb_idx=cursor and set tomb_seen. Then cursor = (cursor+1) mod DEPTH, n = n+1, and remain in PROBE.
- Decision edge: at the edge ending the deciding cycle, rsp_status, rsp_val and rsp_probes=n+1 are registered, rsp_valid=1 and FSM returns to IDLE. rsp_valid drops the following cycle unless another response follows.
- On non-hit outcomes rsp_val = 0.
- Latency: rsp_valid is high in the cycle following the k-th edge after the handshake, where k = rsp_probes, 1 ≤ k ≤ DEPTH.
- Back-to-back: req_ready is high during the rsp_valid cycle, so a new request can be accepted there. Maximum throughput is one command per k+1 cycles… the FSM returns to IDLE at the decision edge, giving one request per (k+1) edges.
- Arithmetic: count never exceeds DEPTH and never underflows. cursor wraps modulo DEPTH.

Test Plan:
1. Reset; LOOKUP key=0x11 hash=3 -> NOTFOUND, probes=1, rsp_val=0, count=0; req_ready=1 throughout idle.
2. INSERT 0x11/0xAA h=3 -> OK probes=1. INSERT 0x22/0xBB h=3 -> OK probes=2 (stored in slot 4). LOOKUP 0x22 h=3 -> OK, val=0xBB, probes=2, count=2.
3. DELETE 0x11 h=3 -> OK, val=0xAA, count=1. LOOKUP 0x22 -> OK probes=2 (traverses the tombstone). INSERT 0x33/0x01 h=3 -> OK probes=3, written to slot 3, count=2. LOOKUP 0x33 -> probes=1.
4. INSERT 0x22/0xCC h=3 -> UPDATED, rsp_val=0xBB, count unchanged. LOOKUP 0x22 -> 0xCC.
5. CLEAR, then 16 INSERTs of distinct keys at h=0 -> all OK, count=16. 17th INSERT -> FULL probes=16. LOOKUP of an absent key -> NOTFOUND probes=16. CLEAR -> OK probes=1, count=0.
6. Reset pulse during a 10-probe LOOKUP -> rsp_valid never pulses; after release req_ready=1, count=0, and earlier keys return NOTFOUND.
